// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/writeback and owns the NZCV flag register.
// Optional macro CTRL_MEMWAIT_EN adds a MemReady port that stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_controller #(
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:12]          Instruction,
    input  logic [3:0]            ALUFlags,
`ifdef CTRL_MEMWAIT_EN
    input  logic                  MemReady,
`endif
    output logic                  PCWrite,
    output logic                  AdrSource,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSource,
    output logic [1:0]            ALUSourceA,
    output logic [1:0]            ALUSourceB,
    output logic [1:0]            ImmediateSource,
    output logic                  RegWrite,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'd0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'd1);

    state_t state, state_nxt;
    logic [3:0] flags;
    logic [3:0] cond, rd, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       unused_rn;
    logic       mem_rdy, cond_ex;
    logic [ALU_CTRL_W-1:0] alu_dp, alu_sel;
    logic       dp_legal, dp_cv, dp_write;
    logic       pcw, irw, memw, regw, adr;
    logic [1:0] ress, srca, srcb;

    assign cond      = Instruction[31:28];
    assign op        = Instruction[27:26];
    assign funct     = Instruction[25:20];
    assign rd        = Instruction[15:12];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instruction[19:16];

`ifdef CTRL_MEMWAIT_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = 1'b1;
`endif

    // flags = {N, Z, C, V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_dp   = ALU_ADD;
        dp_legal = 1'b1;
        dp_cv    = 1'b0;
        case (cmd)
            4'b0100: dp_cv = 1'b1;
            4'b0010, 4'b1010: begin
                alu_dp = ALU_SUB;
                dp_cv  = 1'b1;
            end
            4'b0000: alu_dp = ALU_CTRL_W'(3'd2);
            4'b1100: alu_dp = ALU_CTRL_W'(3'd3);
            4'b0001: begin
                if (ALU_CTRL_W == 3) alu_dp = ALU_CTRL_W'(3'd4);
                else                 dp_legal = 1'b0;
            end
            default: dp_legal = 1'b0;
        endcase
    end

    assign dp_write = dp_legal & (cmd != 4'b1010);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if ((state == S_EXECR || state == S_EXECI) && funct[0] && cond_ex) begin
            flags[3:2] <= ALUFlags[3:2];
            if (dp_cv) flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        adr       = 1'b0;
        ress      = 2'b00;
        srca      = 2'b00;
        srcb      = 2'b00;
        alu_sel   = ALU_ADD;
        pcw       = 1'b0;
        irw       = 1'b0;
        memw      = 1'b0;
        regw      = 1'b0;
        case (state)
            S_FETCH: begin
                srca      = 2'b01;
                srcb      = 2'b10;
                ress      = 2'b10;
                irw       = mem_rdy;
                pcw       = mem_rdy;
                state_nxt = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                srca = 2'b01;
                srcb = 2'b10;
                ress = 2'b10;
                case (op)
                    2'b00:   state_nxt = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                srcb      = 2'b01;
                alu_sel   = funct[3] ? ALU_ADD : ALU_SUB;
                state_nxt = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr       = 1'b1;
                state_nxt = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ress = 2'b01;
                regw = cond_ex;
                pcw  = cond_ex & (rd == 4'hF);
            end
            S_MEMWRITE: begin
                adr       = 1'b1;
                memw      = cond_ex & mem_rdy;
                state_nxt = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_sel   = alu_dp;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                srcb      = 2'b01;
                alu_sel   = alu_dp;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                regw = cond_ex & dp_write;
                pcw  = cond_ex & (rd == 4'hF);
            end
            S_BRANCH: begin
                srca = 2'b10;
                srcb = 2'b01;
                ress = 2'b10;
                pcw  = cond_ex;
            end
            default: ;
        endcase
    end

    // Reset forces FETCH selects via the state register; strobes are gated here.
    assign PCWrite         = pcw  & ~rst;
    assign IRWrite         = irw  & ~rst;
    assign MemWrite        = memw & ~rst;
    assign RegWrite        = regw & ~rst;
    assign AdrSource       = adr;
    assign ResultSource    = ress;
    assign ALUSourceA      = srca;
    assign ALUSourceB      = srcb;
    assign ALUControl      = alu_sel;
    assign ImmediateSource = op;
    assign State           = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a cycle-level reference model predicts every output per cycle.
`timescale 1ns/1ps
module tb_multicycle_controller;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:12] instr = '0;
    logic [3:0]   alu_flags = '0;
`ifdef CTRL_MEMWAIT_EN
    logic         mem_ready = 1'b1;
    localparam int WMAX = 2;
`else
    localparam int WMAX = 0;
`endif
    logic         pc_write, adr_source, mem_write, ir_write, reg_write;
    logic [1:0]   result_source, alu_src_a, alu_src_b, imm_source;
    logic [W-1:0] alu_control;
    logic [3:0]   state;

    multicycle_controller #(.ALU_CTRL_W(W)) dut (
        .clk(clk), .rst(rst), .Instruction(instr), .ALUFlags(alu_flags),
`ifdef CTRL_MEMWAIT_EN
        .MemReady(mem_ready),
`endif
        .PCWrite(pc_write), .AdrSource(adr_source), .MemWrite(mem_write), .IRWrite(ir_write),
        .ResultSource(result_source), .ALUSourceA(alu_src_a), .ALUSourceB(alu_src_b),
        .ImmediateSource(imm_source), .RegWrite(reg_write), .ALUControl(alu_control), .State(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] ress, srca, srcb, imms;
        logic [2:0] aluc;
    } exp_t;

    exp_t sb[$];
    exp_t tr[$];
    bit   tr_rdy[$];
    int   checks = 0;
    int   failures = 0;
    logic [3:0] mflags = 4'b0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ARM condition table: even codes test a predicate, odd codes its inverse.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0], r = 0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1;
        endcase
        if (c[0]) r = !r;
        if (c == 4'hF) r = 0;
        return r;
    endfunction

    function automatic exp_t base(input logic [3:0] st, input logic [1:0] op);
        exp_t e = '0;
        e.st = st;
        e.imms = op;
        return e;
    endfunction

    task automatic add(input exp_t e, input bit r);
        tr.push_back(e);
        tr_rdy.push_back(r);
    endtask

    task automatic add_mem(input exp_t e_wait, input exp_t e_go);
        int w = $urandom_range(WMAX, 0);
        repeat (w) add(e_wait, 0);
        add(e_go, 1);
    endtask

    // Builds the expected cycle trace for one instruction, then drives it (optionally truncated).
    task automatic run_instr(input logic [31:12] ins, input logic [3:0] alf, input int limit);
        logic [3:0] cond = ins[31:28];
        logic [1:0] op = ins[27:26];
        logic [5:0] funct = ins[25:20];
        logic [3:0] rd = ins[15:12];
        logic [3:0] cmd = funct[4:1];
        logic [2:0] code = 0;
        bit legal = 1, cv = 0, ce, ce2;
        exp_t e, ew;
        int n;
        tr.delete();
        tr_rdy.delete();
        case (cmd)
            4'b0100: cv = 1;
            4'b0010: begin code = 1; cv = 1; end
            4'b1010: begin code = 1; cv = 1; end
            4'b0000: code = 2;
            4'b1100: code = 3;
            4'b0001: if (W == 3) code = 4; else legal = 0;
            default: legal = 0;
        endcase
        ew = base(0, op); ew.srca = 1; ew.srcb = 2; ew.ress = 2;
        e = ew; e.irw = 1; e.pcw = 1;
        add_mem(ew, e);
        e = base(1, op); e.srca = 1; e.srcb = 2; e.ress = 2;
        add(e, 1);
        ce = cond_ok(cond, mflags);
        if (op == 2'b00) begin
            e = base(funct[5] ? 4'd7 : 4'd6, op);
            e.srcb = funct[5] ? 2'd1 : 2'd0;
            e.aluc = legal ? code : 3'd0;
            add(e, 1);
            if (funct[0] && ce) begin
                mflags[3:2] = alf[3:2];
                if (cv) mflags[1:0] = alf[1:0];
            end
            ce2 = cond_ok(cond, mflags);
            e = base(8, op);
            e.regw = ce2 && legal && cmd != 4'b1010;
            e.pcw = ce2 && rd == 4'hF;
            add(e, 1);
        end else if (op == 2'b01) begin
            e = base(2, op); e.srcb = 1; e.aluc = funct[3] ? 3'd0 : 3'd1;
            add(e, 1);
            if (funct[0]) begin
                e = base(3, op); e.adr = 1;
                add_mem(e, e);
                e = base(4, op); e.ress = 1; e.regw = ce; e.pcw = ce && rd == 4'hF;
                add(e, 1);
            end else begin
                ew = base(5, op); ew.adr = 1;
                e = ew; e.memw = ce;
                add_mem(ew, e);
            end
        end else if (op == 2'b10) begin
            e = base(9, op); e.srca = 2; e.srcb = 1; e.ress = 2; e.pcw = ce;
            add(e, 1);
        end
        instr = ins;
        alu_flags = alf;
        n = (limit < 0 || limit > tr.size()) ? tr.size() : limit;
        for (int k = 0; k < n; k++) sb.push_back(tr[k]);
        for (int k = 0; k < n; k++) begin
`ifdef CTRL_MEMWAIT_EN
            mem_ready = tr_rdy[k];
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_random(input int count);
        logic [31:12] ins;
        for (int i = 0; i < count; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            run_instr(ins, 4'($urandom), -1);
        end
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = '0;
                g.st = state; g.pcw = pc_write; g.adr = adr_source; g.memw = mem_write;
                g.irw = ir_write; g.regw = reg_write; g.ress = result_source;
                g.srca = alu_src_a; g.srcb = alu_src_b; g.imms = imm_source;
                g.aluc = 3'(alu_control);
                check($sformatf("cycle_st%0d", e.st), 32'(g), 32'(e));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
        check("rst_selects", 32'({adr_source, result_source, alu_src_a, alu_src_b}), 32'({1'b0, 2'b10, 2'b01, 2'b10}));
        check("rst_aluctl", 32'(alu_control), 32'd0);
        rst = 1'b0;

        run_instr({4'hE, 2'b00, 6'b001001, 4'h2, 4'h1}, 4'b0100, -1);  // ADDS, sets Z
        run_instr({4'h0, 2'b10, 6'b000000, 4'h0, 4'h0}, 4'b0000, -1);  // BEQ taken
        run_instr({4'hE, 2'b00, 6'b001001, 4'h2, 4'h1}, 4'b0000, -1);  // ADDS, clears Z
        run_instr({4'h0, 2'b10, 6'b000000, 4'h0, 4'h0}, 4'b0000, -1);  // BEQ not taken
        run_instr({4'hE, 2'b01, 6'b011001, 4'h1, 4'h0}, 4'b0000, -1);  // LDR
        run_instr({4'hE, 2'b01, 6'b010000, 4'h1, 4'h0}, 4'b0000, -1);  // STR with SUB offset
        run_instr({4'hE, 2'b00, 6'b000010, 4'h1, 4'h2}, 4'b0000, -1);  // EOR
        run_instr({4'hE, 2'b00, 6'b110101, 4'h1, 4'h2}, 4'b1011, -1);  // CMP imm
        run_instr({4'hF, 2'b00, 6'b001000, 4'h1, 4'hF}, 4'b0000, -1);  // never-condition
        run_instr({4'hE, 2'b11, 6'b000000, 4'h0, 4'h0}, 4'b0000, -1);  // Op=11
        run_random(300);

        run_instr({4'hE, 2'b01, 6'b011001, 4'h1, 4'h0}, 4'b0000, 3);   // LDR, cut at MEMREAD
        check("pre_rst_state", 32'(state), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_strobes", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_state", 32'(state), 32'd0);
        check("held_rst_strobes", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
        mflags = 4'b0000;
        rst = 1'b0;
        run_instr({4'h0, 2'b10, 6'b000000, 4'h0, 4'h0}, 4'b0100, -1);  // BEQ with cleared Z
        run_random(60);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALU_CTRL_W, default 2: width of ALUControl; the only legal values are 2 and 3.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Instruction  input  20 [31:12]  contents of the registered instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-005 ALUFlags  input  4  current ALU result flags {N,Z,C,V}.
REQ-006 MemReady  input  1  memory-ready handshake; the port exists only when CTRL_MEMWAIT_EN is defined.
REQ-007 PCWrite  output  1  PC load enable.
REQ-008 AdrSource  output  1  memory address select: 0 selects PC, 1 selects Result.
REQ-009 MemWrite  output  1  data memory write strobe.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 ResultSource  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-012 ALUSourceA  output  2  ALU A select: 00 Rn, 01 PC, 10 ALUOut.
REQ-013 ALUSourceB  output  2  ALU B select: 00 Rm, 01 Immediate, 10 constant 4.
REQ-014 ImmediateSource  output  2  extend type; equals Op.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 ALUControl  output  ALU_CTRL_W  ALU operation select.
REQ-017 State  output  4  current FSM state encoding, for debug.

Function
REQ-018 FSM states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-019 Transitions:
  - FETCH->DECODE.
  - DECODE: Op=00 with Funct[5]=0 ->EXECR; Op=00 with Funct[5]=1 ->EXECI; Op=01 ->MEMADR; Op=10 ->BRANCH; Op=11 ->FETCH.
  - MEMADR: Funct[0]=1 ->MEMREAD, otherwise ->MEMWRITE.
  - MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
  - EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
  - Encodings 10-15 ->FETCH.
REQ-020 FETCH outputs: AdrSource=0, IRWrite=1, ALUSourceA=01, ALUSourceB=10, ALUControl=ADD, ResultSource=10, PCWrite=1.
REQ-021 DECODE outputs: ALUSourceA=01, ALUSourceB=10, ALUControl=ADD, ResultSource=10; no strobes asserted.
REQ-022 MEMADR: ALUSourceA=00, ALUSourceB=01, ALUControl=ADD if Funct[3]=1, otherwise SUB.
REQ-023 MEMREAD: AdrSource=1, ResultSource=00.
REQ-024 MEMWB: ResultSource=01, RegWrite=CondEx.
REQ-025 MEMWRITE: AdrSource=1, ResultSource=00, MemWrite=CondEx.
REQ-026 EXECR: ALUSourceA=00, ALUSourceB=00. EXECI: same, except ALUSourceB=01.
REQ-027 ALUWB: ResultSource=00, RegWrite=CondEx, except RegWrite=0 when Cmd=1010 (CMP).
REQ-028 BRANCH: ALUSourceA=10, ALUSourceB=01, ALUControl=ADD, ResultSource=10, PCWrite=CondEx.
REQ-029 PCWrite shall also equal CondEx in MEMWB and ALUWB when Rd=15.
REQ-030 ALU decode in EXECR/EXECI uses Cmd=Funct[4:1]:
  - 0100 ADD=0; 0010 SUB=1; 1010 CMP=1; 0000 AND=2; 1100 ORR=3.
  - ALU_CTRL_W=3 additionally: 0001 EOR=4.
  - Any other Cmd gives ADD with RegWrite=0.
REQ-031 CondEx is evaluated combinationally from Cond against the stored flag register; all 15 ARM conditions are supported, and Cond=1111 gives CondEx=0.
REQ-032 Flag register update occurs at the EXECR/EXECI clock edge when Funct[0]=1 and CondEx=1.
  - N and Z are always loaded.
  - C and V are loaded only for ADD, SUB and CMP.
REQ-033 Latency: branch 3 cycles; data-processing 4; STR 4; LDR 5; Op=11 2.

Reset
REQ-034 While rst=1, State=FETCH and the flag register holds 0000.
REQ-035 While rst=1, PCWrite, IRWrite, MemWrite and RegWrite shall be 0, and the mux selects shall hold their FETCH values.
REQ-036 Assertion of rst in any state, including mid-LDR, shall abort the instruction with no further memory or register write.
REQ-037 After rst deasserts, the first rising edge shall perform a FETCH.

Configuration
REQ-038 Macro CTRL_MEMWAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - IRWrite, PCWrite (in FETCH) and MemWrite assert only in the cycle where MemReady=1.
  - The state advances on that edge.
REQ-039 CTRL_MEMWAIT_EN undefined: the MemReady port is absent and each memory state lasts exactly one cycle.

Verification
REQ-040 ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001, Rd=1) with ALUFlags=0100 -> states 0,1,6,8,0; RegWrite=1 in ALUWB; stored Z=1.
REQ-041 BEQ (Cond=0000, Op=10) after Z=1 -> PCWrite=1 in BRANCH; the same instruction with Z=0 -> PCWrite=0; 3 cycles in both cases.
REQ-042 LDR R0,[R1,#4] (Op=01, Funct=011001) -> states 0,1,2,3,4; ALUControl=0 in MEMADR; RegWrite=1 only in MEMWB.
REQ-043 rst pulsed during MEMREAD -> State=0 immediately and asynchronously; no RegWrite pulse afterwards.
REQ-044 With CTRL_MEMWAIT_EN, STR with MemReady low for 3 cycles -> MEMWRITE held 4 cycles; MemWrite=1 only in the 4th.
REQ-045 With ALU_CTRL_W=3, EOR (Cmd=0001) -> ALUControl=100; with ALU_CTRL_W=2, the same Cmd -> ALUControl=00 and RegWrite=0.
